trace_capture_unit: RTL
=======================

Name: trace_capture_unit

Overview:
Synthesizable debug trace buffer that replaces ad-hoc per-cycle $monitor dumps of the cpu's PC and issue-bus activity. It records one entry per cycle in which any watched channel is valid. Each entry holds a cycle stamp, the channel-valid mask and the PC, written into a circular buffer of parametrised depth. A trigger (PC match or forced) plus a post-trigger count freezes the buffer, which is read back by index from the oldest entry. It sits beside the cpu top, and the bench (or a debug port) drains it.

Parameters:
NUM_CH, 3, number of watched issue channels (alu0, alu1, mem by default)
PC_W, 32, PC width
CYC_W, 16, cycle-stamp width; wraps modulo 2^CYC_W
DEPTH, 16, buffer entries; power of 2, >= 2
AW, $clog2(DEPTH), address width (derived)
ENTRY_W, CYC_W+NUM_CH+PC_W, entry width (derived)

Ports:
clk  in  1  clock, all state on posedge
nrst  in  1  synchronous active-low reset
arm  in  1  single-cycle pulse: clear buffer, load post count, enter ARMED
post_cnt  in  AW+1  captures to take after trigger; sampled only when arm=1
trig_en  in  1  enable PC-match trigger
trig_pc  in  PC_W  PC that fires the trigger
force_trig  in  1  unconditional trigger (ARMED only)
pc  in  PC_W  current PC
ch_valid  in  NUM_CH  per-channel issue valid this cycle
rd_en  in  1  read request
rd_idx  in  AW  read index, 0 = oldest stored entry
rd_data  out  ENTRY_W  {cycle, ch_valid, pc}; registered
rd_valid  out  1  rd_data holds a stored entry
state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
entry_count  out  AW+1  stored entries, saturates at DEPTH
overflow  out  1  buffer has wrapped since last arm
cycle  out  CYC_W  free-running cycle counter

Behaviour:
- Reset (nrst=0 at posedge):
  - state=IDLE; wr_ptr, entry_count, cycle, post count, overflow, rd_data, rd_valid all 0.
  - RAM contents are not reset; stale data is never exposed because reads are gated by rd_valid.
- cycle increments every clock after reset in all states and wraps FFFF->0000 at the default width.
- capture = |ch_valid && state is ARMED or POST.
  - On capture, write {cycle, ch_valid, pc} at wr_ptr, then wr_ptr = wr_ptr+1 mod DEPTH.
  - entry_count increments, saturating at DEPTH.
  - A write that lands when entry_count==DEPTH sets overflow.
- FSM:
  - IDLE -arm-> ARMED. DONE -arm-> ARMED. ARMED and POST also restart on arm.
  - arm clears wr_ptr, entry_count and overflow, and latches post_cnt. No capture occurs in the arm cycle.
  - ARMED: trigger = force_trig || (trig_en && capture && pc==trig_pc). The triggering cycle's entry is captured if capture=1.
    - On trigger with latched count 0 -> DONE.
    - On trigger with nonzero count -> POST, remaining = latched count.
  - POST: each capture decrements remaining; the capture that makes remaining 0 goes -> DONE. force_trig and trig_en are ignored.
  - DONE: no writes; contents are frozen until arm.
  - arm wins over trigger in the same cycle.
- Read:
  - oldest = (entry_count==DEPTH) ? wr_ptr : 0; addr = (oldest + rd_idx) mod DEPTH.
  - Latency is 1 cycle. If rd_en && rd_idx<entry_count: rd_valid=1 and rd_data=entry. Otherwise rd_valid=0 and rd_data=0.
  - Without rd_en, rd_valid=0 and rd_data holds its previous value.
  - Reads are legal in every state.
  - A same-cycle read and write to one address returns the old content (read-before-write). oldest and entry_count are evaluated before the write.
- Reset mid-capture: identical to power-on reset; the next arm starts clean.

Decomposition:
- trace_pkg.h.v (included alongside common.h.v): `define for the state encodings and for the entry field start/end bits, in the same *_start_bit/*_end_bit style as the decoded signal word.
- One sub-module, trace_ram: simple dual-port, DEPTH x ENTRY_W, synchronous write, registered synchronous read, read-before-write.

Test Plan:
- Hold nrst=0 for 2 cycles, then release -> state=0, entry_count=0, overflow=0, rd_valid=0; cycle=1 one clock after release.
- Arm; 5 cycles with ch_valid=001 and pc=0x00,0x04..0x10 -> entry_count=5. Read idx0 -> pc 0x00. Read idx4 -> pc 0x10, ch_valid 001. Read idx5 -> rd_valid=0, rd_data=0.
- Arm; 20 captures with pc=4k for k=0..19 -> entry_count=16, overflow=1, idx0 pc=0x10, idx15 pc=0x4C.
- Arm with post_cnt=3, trig_en=1, trig_pc=0x40; captures pc=0x30,0x34..:
  - After pc 0x40 is captured -> state=2.
  - After 0x44/0x48/0x4C -> state=3.
  - Further valid cycles leave entry_count=8; the last entry has pc 0x4C.
- Arm with post_cnt=0; force_trig=1 with ch_valid=000 -> state=3 next cycle, entry_count=0.
- Arm during POST -> state=1, entry_count=0.
- Gapped captures 3 cycles apart -> stamps differ by 3.
- Captures straddling cycle FFFF->0000 -> stamps are stored as wrapped values.

Source files
------------

// File: rtl/trace_capture_unit_pkg.sv
// rtl/trace_capture_unit_pkg.sv - shared types and entry field layout for the trace capture unit
//
// Purpose: the capture state encoding and helpers that locate the fields of a trace
// entry {cycle, ch_valid, pc}. The pc field sits at the bottom of the entry.
// Ports: none (package).
package trace_capture_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  function automatic int pc_start_bit();
    return 0;
  endfunction

  function automatic int pc_end_bit(input int pc_w);
    return pc_w - 1;
  endfunction

  function automatic int ch_start_bit(input int pc_w);
    return pc_w;
  endfunction

  function automatic int ch_end_bit(input int pc_w, input int num_ch);
    return pc_w + num_ch - 1;
  endfunction

  function automatic int cyc_start_bit(input int pc_w, input int num_ch);
    return pc_w + num_ch;
  endfunction

  function automatic int cyc_end_bit(input int pc_w, input int num_ch, input int cyc_w);
    return pc_w + num_ch + cyc_w - 1;
  endfunction

endpackage

// File: rtl/trace_capture_unit_ram.sv
// rtl/trace_capture_unit_ram.sv - simple dual-port trace storage with registered read
//
// Purpose: DEPTH x W storage, synchronous write, registered synchronous read.
// A read and a write to the same address in one cycle return the old content.
// Ports:
//   clk    clock
//   we     write enable; waddr/wdata write address and data
//   re     read enable; rdata updates only when re=1, otherwise holds
//   raddr  read address
//   rdata  registered read data
module trace_capture_unit_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 51
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a colliding read sees the pre-write word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_capture_unit.sv
// rtl/trace_capture_unit.sv - circular trace buffer of pc / issue-channel activity with trigger
//
// Purpose: records {cycle, ch_valid, pc} on every cycle with any channel valid while
// ARMED or POST. A pc match or forced trigger, followed by post_cnt more captures,
// freezes the buffer. Entries are read back by index, 0 being the oldest.
// Ports:
//   clk, nrst            clock, synchronous active-low reset
//   arm, post_cnt        restart capture and latch the post-trigger capture count
//   trig_en, trig_pc     pc-match trigger
//   force_trig           unconditional trigger while ARMED
//   pc, ch_valid         observed pc and per-channel issue valids
//   rd_en, rd_idx        read request, index from oldest
//   rd_data, rd_valid    read result one cycle later
//   state                0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   entry_count          stored entries, saturating at DEPTH
//   overflow             buffer wrapped since last arm
//   cycle                free-running cycle stamp
module trace_capture_unit
  import trace_capture_unit_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int PC_W    = 32,
  parameter int CYC_W   = 16,
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int ENTRY_W = CYC_W + NUM_CH + PC_W
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               arm,
  input  logic [AW:0]        post_cnt,
  input  logic               trig_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic               force_trig,
  input  logic [PC_W-1:0]    pc,
  input  logic [NUM_CH-1:0]  ch_valid,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_idx,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_valid,
  output logic [1:0]         state,
  output logic [AW:0]        entry_count,
  output logic               overflow,
  output logic [CYC_W-1:0]   cycle
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam int PC_LO  = pc_start_bit();
  localparam int PC_HI  = pc_end_bit(PC_W);
  localparam int CH_LO  = ch_start_bit(PC_W);
  localparam int CH_HI  = ch_end_bit(PC_W, NUM_CH);
  localparam int CYC_LO = cyc_start_bit(PC_W, NUM_CH);
  localparam int CYC_HI = cyc_end_bit(PC_W, NUM_CH, CYC_W);

  trace_state_t state_q, state_d;
  logic [AW-1:0]      wr_ptr;
  logic [AW:0]        cnt_q;
  logic [AW:0]        post_lat;
  logic [AW:0]        remaining;
  logic               overflow_q;
  logic [CYC_W-1:0]   cycle_q;
  logic               capture;
  logic               trigger;
  logic               load_remaining;
  logic               dec_remaining;
  logic [ENTRY_W-1:0] wr_entry;
  logic [AW-1:0]      oldest;
  logic [AW-1:0]      rd_addr;
  logic               rd_hit;
  logic               rd_valid_q;
  logic               rd_zero_q;
  logic [ENTRY_W-1:0] ram_q;

  // The arm cycle itself never captures; arm also overrides any trigger.
  assign capture = (|ch_valid) && !arm && (state_q == ST_ARMED || state_q == ST_POST);
  assign trigger = (state_q == ST_ARMED) &&
                   (force_trig || (trig_en && capture && pc == trig_pc));

  always_ff @(posedge clk) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (arm) begin
      state_d = ST_ARMED;
    end else begin
      case (state_q)
        ST_ARMED: if (trigger) state_d = (post_lat == '0) ? ST_DONE : ST_POST;
        ST_POST:  if (capture && remaining == (AW+1)'(1)) state_d = ST_DONE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_comb begin
    load_remaining = 1'b0;
    dec_remaining  = 1'b0;
    if (!arm) begin
      load_remaining = trigger && (post_lat != '0);
      dec_remaining  = (state_q == ST_POST) && capture;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cycle_q    <= '0;
      wr_ptr     <= '0;
      cnt_q      <= '0;
      post_lat   <= '0;
      remaining  <= '0;
      overflow_q <= 1'b0;
    end else begin
      cycle_q <= cycle_q + CYC_W'(1);
      if (arm) begin
        wr_ptr     <= '0;
        cnt_q      <= '0;
        overflow_q <= 1'b0;
        post_lat   <= post_cnt;
        remaining  <= '0;
      end else begin
        if (capture) begin
          wr_ptr <= wr_ptr + AW'(1);
          if (cnt_q != FULL) cnt_q <= cnt_q + (AW+1)'(1);
          else               overflow_q <= 1'b1;
        end
        if (load_remaining)     remaining <= post_lat;
        else if (dec_remaining) remaining <= remaining - (AW+1)'(1);
      end
    end
  end

  always_comb begin
    wr_entry = '0;
    wr_entry[PC_HI:PC_LO]   = pc;
    wr_entry[CH_HI:CH_LO]   = ch_valid;
    wr_entry[CYC_HI:CYC_LO] = cycle_q;
  end

  // Read address uses the pre-write pointer and count of this cycle.
  assign oldest  = (cnt_q == FULL) ? wr_ptr : '0;
  assign rd_addr = oldest + rd_idx;
  assign rd_hit  = rd_en && ({1'b0, rd_idx} < cnt_q);

  trace_capture_unit_ram #(.DEPTH(DEPTH), .AW(AW), .W(ENTRY_W)) u_ram (
    .clk   (clk),
    .we    (capture),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .re    (rd_hit),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // rd_zero_q masks the RAM output after reset or a miss, and holds while rd_en=0,
  // so rd_data keeps whatever the last request produced.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      rd_valid_q <= rd_hit;
      if (rd_en) rd_zero_q <= !rd_hit;
    end
  end

  assign rd_data     = rd_zero_q ? '0 : ram_q;
  assign rd_valid    = rd_valid_q;
  assign state       = state_q;
  assign entry_count = cnt_q;
  assign overflow    = overflow_q;
  assign cycle       = cycle_q;

endmodule
